// File: rtl/hazard_unit_mc_if.sv
// Hazard-unit bundle between the 5-stage datapath and hazard_unit_mc.
// The datapath side (master) drives register addresses, write enables,
// load/branch/multi-cycle indications. The hazard unit (slave) returns
// forwarding selects, stall/flush controls and multi-cycle status.
interface hazard_unit_mc_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] Rs1D, Rs2D;
  logic [REG_AW-1:0] Rs1E, Rs2E, RdE;
  logic [REG_AW-1:0] RdM, RdW;
  logic              RegWriteE, RegWriteM, RegWriteW;
  logic              ResultSrcE0;
  logic              PCSrcE;
  logic              McStartE;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              StallF, StallD, StallE;
  logic              FlushD, FlushE, FlushM;
  logic              McBusy;
  logic              McDoneE;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteE, RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, McStartE,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE,
    input  FlushD, FlushE, FlushM, McBusy, McDoneE
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteE, RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, McStartE,
    output ForwardAE, ForwardBE, StallF, StallD, StallE,
    output FlushD, FlushE, FlushM, McBusy, McDoneE
  );
endinterface

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage RISC-V pipeline with multi-cycle Execute.
// Provides M/W forwarding (or stall-based RAW resolution when FWD_EN=0),
// load-use stall, branch flush, and an IDLE/BUSY sequencer that holds a
// multi-cycle op in E for MC_LATENCY cycles while bubbling M.
// Ports:
//   clk   - pipeline clock, rising edge
//   reset - asynchronous active-high reset
//   hz    - hazard bundle (slave side): pipeline info in, controls out
module hazard_unit_mc #(
  parameter int REG_AW     = 5,
  parameter int MC_LATENCY = 4,
  parameter bit FWD_EN     = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  hazard_unit_mc_if.slave hz
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [7:0] CNT_LOAD = 8'(MC_LATENCY - 2);

  state_t     state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;

  logic [1:0] fwd_a, fwd_b;
  logic       load_stall, raw_stall, mc_stall, mc_done, hz_stall;

  // Address match that never treats x0 as a hazard source.
  function automatic logic hit(input logic [REG_AW-1:0] a,
                               input logic [REG_AW-1:0] b,
                               input logic              we);
    return we && (a != '0) && (a == b);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Sequencer: the first (IDLE) cycle already stalls, so the counter is
  // loaded with MC_LATENCY-2 and the final BUSY cycle with cnt==0 is done.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    mc_stall   = 1'b0;
    mc_done    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (hz.McStartE) begin
          state_next = BUSY;
          cnt_next   = CNT_LOAD;
          mc_stall   = 1'b1;
        end
      end
      BUSY: begin
        if (cnt_reg != 8'd0) begin
          cnt_next = cnt_reg - 8'd1;
          mc_stall = 1'b1;
        end else begin
          mc_done    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (FWD_EN) begin
      if (hit(hz.Rs1E, hz.RdM, hz.RegWriteM))      fwd_a = 2'b10;
      else if (hit(hz.Rs1E, hz.RdW, hz.RegWriteW)) fwd_a = 2'b01;
      if (hit(hz.Rs2E, hz.RdM, hz.RegWriteM))      fwd_b = 2'b10;
      else if (hit(hz.Rs2E, hz.RdW, hz.RegWriteW)) fwd_b = 2'b01;
    end
  end

  assign load_stall = hz.ResultSrcE0 && (hz.RdE != '0) &&
                      ((hz.Rs1D == hz.RdE) || (hz.Rs2D == hz.RdE));

  // W is never a stall source: the regfile writes on the falling edge.
  assign raw_stall = !FWD_EN &&
                     (hit(hz.Rs1D, hz.RdE, hz.RegWriteE) ||
                      hit(hz.Rs1D, hz.RdM, hz.RegWriteM) ||
                      hit(hz.Rs2D, hz.RdE, hz.RegWriteE) ||
                      hit(hz.Rs2D, hz.RdM, hz.RegWriteM));

  assign hz_stall = load_stall || raw_stall;

  // Everything is forced low while reset is held so an aborted multi-cycle
  // op cannot leak stalls even if McStartE is still asserted.
  always_comb begin
    hz.ForwardAE = 2'b00;
    hz.ForwardBE = 2'b00;
    hz.StallF    = 1'b0;
    hz.StallD    = 1'b0;
    hz.StallE    = 1'b0;
    hz.FlushD    = 1'b0;
    hz.FlushE    = 1'b0;
    hz.FlushM    = 1'b0;
    hz.McBusy    = 1'b0;
    hz.McDoneE   = 1'b0;
    if (!reset) begin
      hz.ForwardAE = fwd_a;
      hz.ForwardBE = fwd_b;
      hz.McBusy    = (state_reg == BUSY);
      hz.McDoneE   = mc_done;
      if (mc_stall) begin
        // Freeze F/D/E, bubble M; load/RAW stalls are masked here.
        hz.StallF = 1'b1;
        hz.StallD = 1'b1;
        hz.StallE = 1'b1;
        hz.FlushM = 1'b1;
      end else begin
        hz.StallF = hz_stall;
        hz.StallD = hz_stall;
        hz.FlushD = hz.PCSrcE;
        hz.FlushE = hz_stall || hz.PCSrcE;
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc: table-driven combinational vectors on a
// forwarding build (a) and a no-forwarding build (c), plus hand-written
// multi-cycle sequences on MC_LATENCY=4 (a) and MC_LATENCY=2 (b).
module tb_hazard_unit_mc;

  // Packed output word:
  // [11:10]FA [9:8]FB [7]StallF [6]StallD [5]StallE [4]FlushD [3]FlushE
  // [2]FlushM [1]McBusy [0]McDoneE
  localparam logic [11:0] NONE = 12'h000;
  localparam logic [11:0] FA10 = 12'h800;
  localparam logic [11:0] FA01 = 12'h400;
  localparam logic [11:0] FB10 = 12'h200;
  localparam logic [11:0] STL  = 12'h0C8;  // StallF StallD FlushE
  localparam logic [11:0] BR   = 12'h018;  // FlushD FlushE
  localparam logic [11:0] MCS  = 12'h0E4;  // StallF/D/E FlushM
  localparam logic [11:0] BSY  = 12'h002;
  localparam logic [11:0] DONE = 12'h003;  // McBusy McDoneE

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
  logic       rwe, rwm, rww, ld, pcs;
  logic       mcs_a, mcs_b;

  hazard_unit_mc_if #(.REG_AW(5)) ifa ();
  hazard_unit_mc_if #(.REG_AW(5)) ifb ();
  hazard_unit_mc_if #(.REG_AW(5)) ifc ();

  assign ifa.Rs1D = rs1d; assign ifa.Rs2D = rs2d; assign ifa.Rs1E = rs1e;
  assign ifa.Rs2E = rs2e; assign ifa.RdE = rde;   assign ifa.RdM = rdm;
  assign ifa.RdW = rdw;   assign ifa.RegWriteE = rwe; assign ifa.RegWriteM = rwm;
  assign ifa.RegWriteW = rww; assign ifa.ResultSrcE0 = ld; assign ifa.PCSrcE = pcs;
  assign ifa.McStartE = mcs_a;

  assign ifb.Rs1D = rs1d; assign ifb.Rs2D = rs2d; assign ifb.Rs1E = rs1e;
  assign ifb.Rs2E = rs2e; assign ifb.RdE = rde;   assign ifb.RdM = rdm;
  assign ifb.RdW = rdw;   assign ifb.RegWriteE = rwe; assign ifb.RegWriteM = rwm;
  assign ifb.RegWriteW = rww; assign ifb.ResultSrcE0 = ld; assign ifb.PCSrcE = pcs;
  assign ifb.McStartE = mcs_b;

  assign ifc.Rs1D = rs1d; assign ifc.Rs2D = rs2d; assign ifc.Rs1E = rs1e;
  assign ifc.Rs2E = rs2e; assign ifc.RdE = rde;   assign ifc.RdM = rdm;
  assign ifc.RdW = rdw;   assign ifc.RegWriteE = rwe; assign ifc.RegWriteM = rwm;
  assign ifc.RegWriteW = rww; assign ifc.ResultSrcE0 = ld; assign ifc.PCSrcE = pcs;
  assign ifc.McStartE = 1'b0;

  hazard_unit_mc #(.REG_AW(5), .MC_LATENCY(4), .FWD_EN(1'b1)) dut_a (.clk(clk), .reset(reset), .hz(ifa));
  hazard_unit_mc #(.REG_AW(5), .MC_LATENCY(2), .FWD_EN(1'b1)) dut_b (.clk(clk), .reset(reset), .hz(ifb));
  hazard_unit_mc #(.REG_AW(5), .MC_LATENCY(4), .FWD_EN(1'b0)) dut_c (.clk(clk), .reset(reset), .hz(ifc));

  logic [11:0] out_a, out_b, out_c;
  assign out_a = {ifa.ForwardAE, ifa.ForwardBE, ifa.StallF, ifa.StallD, ifa.StallE,
                  ifa.FlushD, ifa.FlushE, ifa.FlushM, ifa.McBusy, ifa.McDoneE};
  assign out_b = {ifb.ForwardAE, ifb.ForwardBE, ifb.StallF, ifb.StallD, ifb.StallE,
                  ifb.FlushD, ifb.FlushE, ifb.FlushM, ifb.McBusy, ifb.McDoneE};
  assign out_c = {ifc.ForwardAE, ifc.ForwardBE, ifc.StallF, ifc.StallD, ifc.StallE,
                  ifc.FlushD, ifc.FlushE, ifc.FlushM, ifc.McBusy, ifc.McDoneE};

  // Branch and multi-cycle start never coincide in legal decode.
  always @(posedge clk) begin
    assert (!(pcs && (mcs_a || mcs_b))) else $error("PCSrcE with McStartE");
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%03h want=%03h", nm, act, exp);
    end else begin
      $display("ok   %s: got=%03h", nm, act);
    end
  endtask

  typedef struct {
    bit          fwd;
    logic [4:0]  rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic        rwe, rwm, rww, ld, pcs;
    logic [11:0] exp;
  } vec_t;

  function automatic vec_t mk(bit f, logic [4:0] a1d, a2d, a1e, a2e, de, dm, dw,
                              logic we, wm, ww, l, p, logic [11:0] e);
    vec_t v;
    v.fwd = f; v.rs1d = a1d; v.rs2d = a2d; v.rs1e = a1e; v.rs2e = a2e;
    v.rde = de; v.rdm = dm; v.rdw = dw;
    v.rwe = we; v.rwm = wm; v.rww = ww; v.ld = l; v.pcs = p; v.exp = e;
    return v;
  endfunction

  task automatic clear_in();
    rs1d = 0; rs2d = 0; rs1e = 0; rs2e = 0; rde = 0; rdm = 0; rdw = 0;
    rwe = 0; rwm = 0; rww = 0; ld = 0; pcs = 0; mcs_a = 0; mcs_b = 0;
  endtask

  vec_t vt[15];

  initial begin
    //          f  r1d r2d r1e r2e rdE rdM rdW  wE wM wW ld pc  expected
    vt[0]  = mk(1, 0,  0,  5,  0,  0,  5,  5,   0, 1, 1, 0, 0, FA10);
    vt[1]  = mk(1, 0,  0,  5,  0,  0,  5,  5,   0, 0, 1, 0, 0, FA01);
    vt[2]  = mk(1, 0,  0,  0,  0,  0,  5,  5,   0, 1, 1, 0, 0, NONE);
    vt[3]  = mk(1, 0,  0,  4,  9,  0,  9,  4,   0, 1, 1, 0, 0, FA01 | FB10);
    vt[4]  = mk(1, 0,  7,  0,  0,  7,  0,  0,   1, 0, 0, 1, 0, STL);
    vt[5]  = mk(1, 0,  0,  0,  0,  0,  0,  0,   1, 0, 0, 1, 0, NONE);
    vt[6]  = mk(1, 0,  0,  0,  0,  0,  0,  0,   0, 0, 0, 0, 1, BR);
    vt[7]  = mk(1, 0,  0,  0,  0,  0,  0,  0,   0, 1, 1, 0, 0, NONE);
    vt[8]  = mk(1, 3,  0,  0,  0,  3,  0,  0,   1, 0, 0, 0, 0, NONE);
    vt[9]  = mk(0, 3,  0,  3,  0,  0,  3,  0,   0, 1, 0, 0, 0, STL);
    vt[10] = mk(0, 3,  0,  3,  0,  0,  0,  3,   0, 0, 1, 0, 0, NONE);
    vt[11] = mk(0, 0,  0,  0,  0,  0,  0,  0,   0, 0, 0, 0, 1, BR);
    vt[12] = mk(0, 0,  6,  0,  0,  6,  0,  0,   1, 0, 0, 0, 0, STL);
    vt[13] = mk(0, 0,  0,  0,  0,  0,  0,  0,   1, 1, 1, 0, 0, NONE);
    vt[14] = mk(0, 7,  0,  0,  0,  7,  0,  0,   1, 0, 0, 1, 0, STL);

    clear_in();
    reset = 1'b1;
    #2;
    chk("reset_a", out_a, NONE);
    chk("reset_b", out_b, NONE);
    chk("reset_c", out_c, NONE);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      clear_in();
      rs1d = vt[i].rs1d; rs2d = vt[i].rs2d; rs1e = vt[i].rs1e; rs2e = vt[i].rs2e;
      rde = vt[i].rde; rdm = vt[i].rdm; rdw = vt[i].rdw;
      rwe = vt[i].rwe; rwm = vt[i].rwm; rww = vt[i].rww; ld = vt[i].ld; pcs = vt[i].pcs;
      #1;
      chk($sformatf("vec%0d_fwd%0d", i, vt[i].fwd), vt[i].fwd ? out_a : out_c, vt[i].exp);
    end

    // MC_LATENCY=4: three stall cycles then done; McStartE held 4 cycles.
    @(negedge clk); clear_in(); mcs_a = 1'b1;
    #1 chk("mc4_c1", out_a, MCS);
    @(negedge clk); #1 chk("mc4_c2", out_a, MCS | BSY);
    @(negedge clk); #1 chk("mc4_c3", out_a, MCS | BSY);
    @(negedge clk); #1 chk("mc4_c4_done", out_a, DONE);
    @(negedge clk); mcs_a = 1'b0;
    #1 chk("mc4_after", out_a, NONE);

    // MC_LATENCY=2 back-to-back: stall, done, stall, done.
    @(negedge clk); mcs_b = 1'b1;
    #1 chk("mc2_op1_stall", out_b, MCS);
    @(negedge clk); #1 chk("mc2_op1_done", out_b, DONE);
    @(negedge clk); #1 chk("mc2_op2_stall", out_b, MCS);
    @(negedge clk); #1 chk("mc2_op2_done", out_b, DONE);
    @(negedge clk); mcs_b = 1'b0;
    #1 chk("mc2_after", out_b, NONE);

    // Reset while BUSY with cnt==1 aborts immediately.
    @(negedge clk); mcs_a = 1'b1;
    #1 chk("rst_c1", out_a, MCS);
    @(negedge clk); #1 chk("rst_c2", out_a, MCS | BSY);
    @(negedge clk); #1 chk("rst_c3_cnt1", out_a, MCS | BSY);
    reset = 1'b1;
    #1 chk("rst_abort", out_a, NONE);
    @(negedge clk); #1 chk("rst_held", out_a, NONE);
    mcs_a = 1'b0;
    @(negedge clk); reset = 1'b0;
    #1 chk("rst_release", out_a, NONE);
    @(negedge clk); #1 chk("rst_no_done", out_a, NONE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
